// File: rtl/oled_pkg.sv
// Shared types and constants for the OLED frame sequencer.
// Holds the state encoding, command bytes and the panel init list.
package oled_pkg;

  typedef enum logic [2:0] {
    RES_HI,
    RES_LO,
    RES_WAIT,
    INIT,
    IDLE,
    PCMD,
    FETCH,
    DATA
  } state_t;

  localparam int INIT_LEN = 28;

  localparam logic [7:0] SET_PAGE = 8'hB0;
  localparam logic [7:0] COL_LO   = 8'h00;
  localparam logic [7:0] COL_HI   = 8'h10;

  localparam logic [7:0] INIT_LIST [INIT_LEN] = '{
    8'hAE, 8'h00, 8'h10, 8'h40,
    8'h81, 8'hCF, 8'hA1, 8'hC8,
    8'hA6, 8'hA8, 8'h3F, 8'hD3,
    8'h00, 8'hD5, 8'h80, 8'hD9,
    8'hF1, 8'hDA, 8'h12, 8'hDB,
    8'h40, 8'h20, 8'h02, 8'h8D,
    8'h14, 8'hA4, 8'hA6, 8'hAF
  };

endpackage

// File: rtl/oled_frame_sequencer_if.sv
// Byte handshake between the sequencer and spi_byte_tx.
// The sequencer is master; the transmitter is slave.
interface oled_frame_sequencer_if;

  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] tx_data;
  logic       tx_dc;

  modport master (
    output tx_valid,
    output tx_data,
    output tx_dc,
    input  tx_ready
  );

  modport slave (
    input  tx_valid,
    input  tx_data,
    input  tx_dc,
    output tx_ready
  );

endinterface

// File: rtl/oled_init_rom.sv
// Combinational lookup of the panel init command list.
// Indices past the list return 0x00.
module oled_init_rom
  import oled_pkg::*;
(
  input  logic [4:0] idx,
  output logic [7:0] data
);

  always_comb begin
    data = 8'h00;
    if (idx < 5'(INIT_LEN))
      data = INIT_LIST[idx];
  end

endmodule

// File: rtl/oled_frame_sequencer.sv
// Reset pulse, init playback and full-frame refresh for an
// SSD1306-class panel over a byte-level SPI transmitter.
module oled_frame_sequencer
  import oled_pkg::*;
#(
  parameter int DELAY_CYC = 100_000,
  parameter int DLY_W     = 20,
  parameter int COLS      = 128,
  parameter int PAGES     = 8
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       refresh_req,
  oled_frame_sequencer_if.master tx,
  output logic       oled_res,
  output logic [9:0] fb_addr,
  input  logic [7:0] fb_data,
  output logic       init_done,
  output logic       busy,
  output logic       frame_done
);

  localparam logic [DLY_W-1:0] DLY_LAST =
    DLY_W'(DELAY_CYC - 1);
  localparam logic [6:0] COL_LAST  = 7'(COLS - 1);
  localparam logic [2:0] PAGE_LAST = 3'(PAGES - 1);
  localparam logic [4:0] IDX_LAST  = 5'(INIT_LEN - 1);

  state_t           state, state_d;
  logic [DLY_W-1:0] dly, dly_d;
  logic [4:0]       idx, idx_d;
  logic [1:0]       sub, sub_d;
  logic [2:0]       page, page_d;
  logic [6:0]       col, col_d;
  logic             pending, pending_d;
  logic             init_q, init_d;
  logic             fd_q, fd_d;
  logic             held, held_d;
  logic [7:0]       data_q, data_d;

  logic [7:0] rom_byte;
  logic [7:0] tx_byte;
  logic       tx_dc_c;
  logic       xfer;

  oled_init_rom u_rom (
    .idx  (idx),
    .data (rom_byte)
  );

  assign tx.tx_valid = (state == INIT) ||
                       (state == PCMD) ||
                       (state == DATA);
  assign tx.tx_data  = tx_byte;
  assign tx.tx_dc    = tx_dc_c;
  assign xfer        = tx.tx_valid && tx.tx_ready;

  assign oled_res   = (state != RES_LO);
  assign busy       = (state != IDLE);
  assign fb_addr    = {page, col};
  assign init_done  = init_q;
  assign frame_done = fd_q;

  // Framebuffer byte is latched if the transmitter stalls,
  // so the offered byte cannot drift while tx_valid is high.
  always_comb begin
    tx_byte = 8'h00;
    tx_dc_c = 1'b0;
    unique case (state)
      INIT: tx_byte = rom_byte;
      PCMD: begin
        unique case (sub)
          2'd0:    tx_byte = SET_PAGE | {5'd0, page};
          2'd1:    tx_byte = COL_LO;
          default: tx_byte = COL_HI;
        endcase
      end
      DATA: begin
        tx_byte = held ? data_q : fb_data;
        tx_dc_c = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state;
    dly_d     = dly;
    idx_d     = idx;
    sub_d     = sub;
    page_d    = page;
    col_d     = col;
    pending_d = pending | refresh_req;
    init_d    = init_q;
    fd_d      = 1'b0;
    held_d    = held;
    data_d    = data_q;
    unique case (state)
      RES_HI, RES_LO, RES_WAIT: begin
        if (dly == DLY_LAST) begin
          dly_d = '0;
          unique case (state)
            RES_HI:  state_d = RES_LO;
            RES_LO:  state_d = RES_WAIT;
            default: state_d = INIT;
          endcase
        end else begin
          dly_d = dly + 1'b1;
        end
      end
      INIT: begin
        if (xfer) begin
          if (idx == IDX_LAST) begin
            idx_d   = '0;
            init_d  = 1'b1;
            state_d = IDLE;
          end else begin
            idx_d = idx + 1'b1;
          end
        end
      end
      IDLE: begin
        pending_d = 1'b0;
        if (pending || refresh_req) begin
          page_d  = '0;
          state_d = PCMD;
        end
      end
      PCMD: begin
        if (xfer) begin
          if (sub == 2'd2) begin
            sub_d   = '0;
            col_d   = '0;
            state_d = FETCH;
          end else begin
            sub_d = sub + 1'b1;
          end
        end
      end
      FETCH: begin
        held_d  = 1'b0;
        state_d = DATA;
      end
      DATA: begin
        if (xfer) begin
          held_d = 1'b0;
          if (col != COL_LAST) begin
            col_d   = col + 1'b1;
            state_d = FETCH;
          end else if (page != PAGE_LAST) begin
            page_d  = page + 1'b1;
            state_d = PCMD;
          end else begin
            fd_d    = 1'b1;
            state_d = IDLE;
          end
        end else if (!held) begin
          held_d = 1'b1;
          data_d = fb_data;
        end
      end
      default: state_d = RES_HI;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state   <= RES_HI;
      dly     <= '0;
      idx     <= '0;
      sub     <= '0;
      page    <= '0;
      col     <= '0;
      pending <= 1'b0;
      init_q  <= 1'b0;
      fd_q    <= 1'b0;
      held    <= 1'b0;
      data_q  <= 8'h00;
    end else begin
      state   <= state_d;
      dly     <= dly_d;
      idx     <= idx_d;
      sub     <= sub_d;
      page    <= page_d;
      col     <= col_d;
      pending <= pending_d;
      init_q  <= init_d;
      fd_q    <= fd_d;
      held    <= held_d;
      data_q  <= data_d;
    end
  end

endmodule
